seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked ALU for the datapath experiments. Supports add/sub with full SF/ZF/CF/OF flags, bitwise logic, barrel shifts and an optional multi-cycle shift-add multiplier. It accepts one operation at a time over a valid/ready input channel and holds a registered result, with flags, on a valid/ready output channel until it is consumed.

## Interface
- WIDTH, 8, operand/result width in bits; must be at least 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operands and opcode presented
- in_ready  out  1  block can accept; high only in IDLE
- num1  in  WIDTH  operand A
- num2  in  WIDTH  operand B; for shifts, only num2[SHW-1:0] is used
- control  in  4  opcode
- m  in  1  0 = add, 1 = subtract (opcodes 0000/0001 only)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result (low half for MUL)
- result_hi  out  WIDTH  high half of MUL product; 0 for all other ops
- sf, zf, cf, of  out  1 each  registered flags

## Operation
- Opcodes:
  - 0000 ADD/SUB unsigned.
  - 0001 ADD/SUB signed. Arithmetic and flags are identical to 0000.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLL.
  - 0110 SRL.
  - 0111 SRA.
  - 1000 MUL (unsigned).
  - All others are unsupported.
- ADD/SUB: SUB = num1 + ~num2 + 1, modulo 2^WIDTH.
  - cf = carry-out XOR m, i.e. carry for add, borrow for sub.
  - of = carry into MSB XOR carry out of MSB.
- Logic ops: cf = 0, of = 0.
- Shifts by s = num2[SHW-1:0]:
  - cf = last bit shifted out; cf = 0 when s = 0.
  - of = 0.
  - SRA fills with num1[WIDTH-1].
- MUL: 2·WIDTH-bit product, computed iteratively, one partial-product step per cycle.
  - {result_hi, result} = product.
  - cf = of = (result_hi != 0).
  - zf = (product == 0).
  - sf = result[WIDTH-1].
- Unsupported opcode: result = 0, result_hi = 0, zf = 1, sf = cf = of = 0. Single-cycle.
- For all non-MUL ops: sf = result[WIDTH-1], zf = (result == 0).
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready = 1. On in_valid, capture operands and opcode.
  - From IDLE, MUL opcode → MUL; any other opcode → DONE, with result and flags registered on the same edge.
  - MUL: step counter runs 0..WIDTH-1. At count WIDTH-1, register the product and flags → DONE.
  - DONE: out_valid = 1. On out_ready → IDLE.
- Operand and opcode changes after acceptance have no effect on the operation in flight.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, out_valid = 0.
  - result = 0, result_hi = 0, all flags = 0, MUL counter = 0.
  - in_ready = 1 from the first edge with rst_n high.
- Reset mid-MUL or while in DONE aborts the operation. The result is discarded; out_valid is 0 on the next cycle.
- Latency, measured from the accept edge (in_valid & in_ready) to out_valid high:
  - non-MUL: 1 cycle.
  - MUL: WIDTH + 1 cycles.
- Throughput:
  - In DONE and MUL, in_ready = 0. No accept in the same cycle as out handshake.
  - Maximum is one op per 2 cycles (non-MUL).
- Backpressure: while out_valid & !out_ready, result, result_hi and all flags hold stable.
- out_valid drops the cycle after the out_ready handshake edge.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- SEQ_ALU_MUL_EN defined: opcode 1000 uses the multi-cycle multiplier, state MUL and the counter as described above.
- SEQ_ALU_MUL_EN undefined:
  - Multiplier, counter and MUL state are not built.
  - Opcode 1000 is treated as unsupported (1-cycle; result 0, zf = 1).
  - result_hi is tied to 0.

## Test plan
- WIDTH=8, ctrl 0000, m=0, 200+100 → result 0x2C, cf=1, of=0, sf=0, zf=0; out_valid exactly 1 cycle after accept.
- WIDTH=8, ctrl 0001, m=1:
  - 0x80−0x01 → 0x7F, of=1, cf=0, sf=0.
  - 3−5 → 0xFE, cf=1, sf=1.
  - 5−5 → 0x00, zf=1, cf=0.
- WIDTH=8 shifts:
  - SLL 0x81 by 1 → 0x02, cf=1.
  - SRA 0x90 by 2 → 0xE4, cf=0.
  - SRL 0x90 by 0 → 0x90, cf=0.
  - XOR 0xFF,0xFF → 0x00, zf=1.
- WIDTH=8 with SEQ_ALU_MUL_EN defined:
  - 15×17 → result 0xFF, result_hi 0x00, cf=of=0; out_valid exactly 9 cycles after accept.
  - 16×16 → result 0x00, result_hi 0x01, cf=of=1, zf=0.
  - Without the macro, 16×16 → result 0x00, result_hi 0x00, zf=1, 1-cycle latency.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE → outputs constant, in_ready=0, new in_valid ignored.
  - Pulse rst_n low at MUL step 3 → next cycle out_valid=0, result=0, flags=0, in_ready=1.
- WIDTH=16 regression: 0x7FFF+0x0001 → 0x8000, of=1, sf=1, cf=0.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU.
//
// One operation is accepted at a time over a valid/ready input channel. The
// result and flags are registered and held on a valid/ready output channel
// until they are consumed. Single-cycle ops: ADD/SUB (unsigned/signed), AND,
// OR, XOR, SLL, SRL, SRA. Opcode 1000 is an iterative shift-add multiplier
// built only when the macro SEQ_ALU_MUL_EN is defined. Without the macro,
// 1000 is treated as unsupported and result_hi is tied to zero.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready high only in IDLE)
//   num1, num2           operands (shifts use num2[SHW-1:0] only)
//   control              opcode
//   m                    0 = add, 1 = subtract (opcodes 0000/0001)
//   out_valid/out_ready  output handshake
//   result, result_hi    registered result / high half of MUL product
//   sf, zf, cf, of       registered flags
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [3:0]       control,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             sf,
    output logic             zf,
    output logic             cf,
    output logic             of
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADDU = 4'b0000;
    localparam logic [3:0] OP_ADDS = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state, state_next;

    // ---------------- single-cycle datapath (uses live inputs in IDLE) ----
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_low;
    logic [WIDTH:0]   sll_x, srl_x, sra_x;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf, alu_of;

    always_comb begin
        shamt    = num2[SHW-1:0];
        b_eff    = num2 ^ {WIDTH{m}};
        add_full = {1'b0, num1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, m};
        // add_low[WIDTH-1] is the carry into the MSB
        add_low  = {1'b0, num1[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, m};
        // Shifts carry one guard bit so the last bit shifted out lands in it
        // (and is naturally 0 when the shift amount is 0).
        sll_x    = {1'b0, num1} << shamt;
        srl_x    = {num1, 1'b0} >> shamt;
        sra_x    = $signed({num1, 1'b0}) >>> shamt;

        alu_res = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        case (control)
            OP_ADDU, OP_ADDS: begin
                alu_res = add_full[WIDTH-1:0];
                alu_cf  = add_full[WIDTH] ^ m;
                alu_of  = add_low[WIDTH-1] ^ add_full[WIDTH];
            end
            OP_AND: alu_res = num1 & num2;
            OP_OR:  alu_res = num1 | num2;
            OP_XOR: alu_res = num1 ^ num2;
            OP_SLL: begin
                alu_res = sll_x[WIDTH-1:0];
                alu_cf  = sll_x[WIDTH];
            end
            OP_SRL: begin
                alu_res = srl_x[WIDTH:1];
                alu_cf  = srl_x[0];
            end
            OP_SRA: begin
                alu_res = sra_x[WIDTH:1];
                alu_cf  = sra_x[0];
            end
            default: ;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // ---------------- iterative shift-add multiplier ----------------------
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] mul_acc, mul_acc_next;
    logic [SHW-1:0]     mul_cnt;
    logic               mul_last;

    always_comb begin
        mul_last     = (mul_cnt == SHW'(WIDTH - 1));
        mul_acc_next = mul_acc;
        if (mul_b[mul_cnt]) begin
            mul_acc_next = mul_acc + ({{WIDTH{1'b0}}, mul_a} << mul_cnt);
        end
    end
`endif

    // ---------------- control FSM ----------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    state_next = (control == OP_MUL) ? MUL : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            MUL: if (mul_last) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ---------------- result / flag registers ----------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            sf     <= 1'b0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            of     <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            result_hi <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_acc   <= '0;
            mul_cnt   <= '0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                if (control == OP_MUL) begin
                    mul_a   <= num1;
                    mul_b   <= num2;
                    mul_acc <= '0;
                    mul_cnt <= '0;
                end else
`endif
                begin
                    result <= alu_res;
                    sf     <= alu_res[WIDTH-1];
                    zf     <= (alu_res == '0);
                    cf     <= alu_cf;
                    of     <= alu_of;
`ifdef SEQ_ALU_MUL_EN
                    result_hi <= '0;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            if (state == MUL) begin
                mul_acc <= mul_acc_next;
                mul_cnt <= mul_cnt + SHW'(1);
                if (mul_last) begin
                    result    <= mul_acc_next[WIDTH-1:0];
                    result_hi <= mul_acc_next[2*WIDTH-1:WIDTH];
                    sf        <= mul_acc_next[WIDTH-1];
                    zf        <= (mul_acc_next == '0);
                    cf        <= (mul_acc_next[2*WIDTH-1:WIDTH] != '0);
                    of        <= (mul_acc_next[2*WIDTH-1:WIDTH] != '0);
                end
            end
`endif
        end
    end

`ifndef SEQ_ALU_MUL_EN
    assign result_hi = '0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: scoreboard with a behavioural reference model.
// The driver pushes the model's expected response when an op is accepted;
// a negedge monitor pops and checks when the DUT presents out_valid, and
// randomly applies backpressure on out_ready.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] num1 = '0, num2 = '0;
    logic [3:0] control = '0;
    logic       m = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result, result_hi;
    logic       sf, zf, cf, of;

    logic        iv16 = 1'b0, or16 = 1'b1, m16 = 1'b0;
    logic        ir16, ov16;
    logic [15:0] a16 = '0, b16 = '0, r16, rh16;
    logic [3:0]  c16 = '0;
    logic        sf16, zf16, cf16, of16;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .control(control), .m(m),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .sf(sf), .zf(zf), .cf(cf), .of(of)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .num1(a16), .num2(b16), .control(c16), .m(m16),
        .out_valid(ov16), .out_ready(or16),
        .result(r16), .result_hi(rh16),
        .sf(sf16), .zf(zf16), .cf(cf16), .of(of16)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] flg;   // {sf, zf, cf, of}
        int         lat;
        int         acc;
        bit         hold;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0, passes = 0, fails = 0;
    bit   mon_en = 1'b1, holding = 1'b0, drop_pending = 1'b0;
    int   hold_left = 0;
    int   n_issued = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] c, input logic mm);
        exp_t   e;
        longint ua, ub, sa, sb, r, rs;
        int     s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b[2:0]);
        e.res = '0; e.hi = '0; e.lat = 1; e.acc = 0; e.hold = 1'b0;
        e.flg = '0;
        case (c)
            4'd0, 4'd1: begin
                if (!mm) begin r = ua + ub; e.flg[1] = (r > 255); end
                else     begin r = ua - ub; e.flg[1] = (ua < ub); end
                e.res = r[7:0];
                rs = mm ? (sa - sb) : (sa + sb);
                e.flg[0] = (rs > 127) || (rs < -128);
            end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: begin
                r = ua * (longint'(1) << s);
                e.res = r[7:0];
                e.flg[1] = (s != 0) && r[8];
            end
            4'd6: begin
                r = ua / (longint'(1) << s);
                e.res = r[7:0];
                if (s != 0) e.flg[1] = a[s-1];
            end
            4'd7: begin
                r = sa >>> s;
                e.res = r[7:0];
                if (s != 0) e.flg[1] = a[s-1];
            end
`ifdef SEQ_ALU_MUL_EN
            4'd8: begin
                r = ua * ub;
                e.res = r[7:0];
                e.hi  = r[15:8];
                e.lat = 9;
                e.flg[1] = (e.hi != 0);
                e.flg[0] = (e.hi != 0);
            end
`endif
            default: ;
        endcase
        e.flg[3] = e.res[7];
        e.flg[2] = (e.res == 0) && (e.hi == 0);
        return e;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, input logic mm, input bit push, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        num1 = a; num2 = b; control = c; m = mm; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e = model(a, b, c, mm);
            e.acc  = edge_cnt;
            e.hold = hold;
            q.push_back(e);
        end
        in_valid = 1'b0;
        num1 = 8'($urandom); num2 = 8'($urandom);
        control = 4'($urandom); m = 1'($urandom);
        n_issued++;
    endtask

    // Monitor / scoreboard checker
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                out_ready = 1'b0;
            end else begin
                chk("ready_valid_excl", in_ready & out_valid, 0);
                if (drop_pending) begin
                    chk("valid_drop", out_valid, 0);
                    drop_pending = 1'b0;
                    out_ready = 1'b0;
                end else if (out_valid) begin
                    if (!holding) begin
                        chk("expected_pending", q.size() != 0, 1);
                        if (q.size() != 0) begin
                            cur = q.pop_front();
                            chk("latency", edge_cnt - cur.acc + 1, cur.lat);
                            chk("result", result, cur.res);
                            chk("result_hi", result_hi, cur.hi);
                            chk("flags", {sf, zf, cf, of}, cur.flg);
                            hold_left = cur.hold ? 5 : 0;
                        end
                        holding = 1'b1;
                    end else begin
                        chk("hold_result", result, cur.res);
                        chk("hold_result_hi", result_hi, cur.hi);
                        chk("hold_flags", {sf, zf, cf, of}, cur.flg);
                    end
                    if (hold_left > 0) begin
                        out_ready = 1'b0;
                        hold_left--;
                    end else begin
                        out_ready = ($urandom_range(0, 2) != 0);
                    end
                    if (out_ready) begin
                        holding = 1'b0;
                        drop_pending = 1'b1;
                    end
                end else begin
                    out_ready = 1'b0;
                end
            end
        end
    end

    task automatic reset_pulse_check(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_result"}, {result_hi, result}, 0);
        chk({tag, "_flags"}, {sf, zf, cf, of}, 0);
    endtask

    typedef struct { logic [7:0] a; logic [7:0] b; logic [3:0] c; logic mm; } vec_t;
    vec_t dir[$];

    initial begin
        int n;
        logic [3:0] c;
        dir = '{
            '{8'd200, 8'd100, 4'd0, 1'b0},
            '{8'h80,  8'h01,  4'd1, 1'b1},
            '{8'd3,   8'd5,   4'd1, 1'b1},
            '{8'd5,   8'd5,   4'd1, 1'b1},
            '{8'h81,  8'h01,  4'd5, 1'b0},
            '{8'h90,  8'h02,  4'd7, 1'b0},
            '{8'h90,  8'h00,  4'd6, 1'b0},
            '{8'hFF,  8'hFF,  4'd4, 1'b0},
            '{8'd15,  8'd17,  4'd8, 1'b0},
            '{8'd16,  8'd16,  4'd8, 1'b0},
            '{8'hF0,  8'h3C,  4'd2, 1'b0},
            '{8'hF0,  8'h3C,  4'd3, 1'b0},
            '{8'h12,  8'h34,  4'hF, 1'b0}
        };

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", {result_hi, result}, 0);
        chk("rst_flags", {sf, zf, cf, of}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // 16-bit instance, directed
        a16 = 16'h7FFF; b16 = 16'h0001; c16 = 4'd0; m16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1; iv16 = 1'b0;
        @(negedge clk);
        chk("w16_valid", ov16, 1);
        chk("w16_add_result", r16, 32'h8000);
        chk("w16_add_flags", {sf16, zf16, cf16, of16}, 4'b1001);
        @(negedge clk);
        a16 = 16'h0001; b16 = 16'h0002; c16 = 4'd1; m16 = 1'b1; iv16 = 1'b1;
        @(posedge clk); #1; iv16 = 1'b0;
        @(negedge clk);
        chk("w16_sub_result", r16, 32'hFFFF);
        chk("w16_sub_flags", {sf16, zf16, cf16, of16}, 4'b1010);

        // Directed then random ops through the scoreboard
        foreach (dir[i]) issue(dir[i].a, dir[i].b, dir[i].c, dir[i].mm, 1'b1, (i % 4) == 1);
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
            else                          c = 4'($urandom_range(0, 8));
            issue(8'($urandom), 8'($urandom), c, 1'($urandom), 1'b1, (i % 8) == 3);
        end

        n = 0;
        while ((q.size() != 0 || holding || drop_pending) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (q.size() == 0) && !holding && !drop_pending, 1);

        // Reset while in DONE, and (with the multiplier) mid-MUL
        mon_en = 1'b0;
        @(negedge clk);
        issue(8'd200, 8'd100, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_before_rst", {out_valid, result}, {1'b1, 8'h2C});
        reset_pulse_check("rst_done");
`ifdef SEQ_ALU_MUL_EN
        issue(8'd15, 8'd17, 4'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_pulse_check("rst_mul");
        repeat (12) @(negedge clk);
        chk("rst_mul_no_late_valid", out_valid, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end
endmodule
